// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for the EX stage.
// Returns {remainder, quotient} with a done strobe and stalls the pipe while busy.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    input  logic               annul,
    output logic [2*WIDTH-1:0] div_result,
    output logic               done,
    output logic               stall_req
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;

    logic             accept;
    logic             div_zero;
    logic             last;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_sub;
    logic [WIDTH:0]   rem_nx;
    logic             ge;
    logic [WIDTH-1:0] quot_nx;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

    assign accept   = (state == IDLE) && start && !annul;
    assign div_zero = (divisor == '0);
    assign last     = (cnt == CW'(WIDTH - 1));

    // Unsigned mode uses the operands as plain magnitudes.
    assign a_abs = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
    assign b_abs = (signed_div && divisor[WIDTH-1]) ? -divisor : divisor;

    // One restoring step: shift in the next dividend bit, trial-subtract.
    // rem[WIDTH] folded into ge keeps the compare exact at full range.
    assign rem_sh  = {rem[WIDTH-1:0], quot[WIDTH-1]};
    assign rem_sub = rem_sh - {1'b0, dvs};
    assign ge      = rem[WIDTH] || (rem_sh >= {1'b0, dvs});
    assign rem_nx  = ge ? rem_sub : rem_sh;
    assign quot_nx = {quot[WIDTH-2:0], ge};

    // Sign correction applied on the final step only.
    assign q_fin = neg_q ? -quot_nx : quot_nx;
    assign r_fin = neg_r ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];

    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and stall request; annul wins over completion.
    always_comb begin
        state_d   = state;
        stall_req = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall_req = 1'b1;
                    state_d   = div_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                stall_req = 1'b1;
                if (annul) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, iteration and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            rem        <= '0;
            quot       <= '0;
            dvs        <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (div_zero) begin
                            div_result <= {dividend, {WIDTH{1'b1}}};
                        end else begin
                            cnt   <= '0;
                            rem   <= '0;
                            quot  <= a_abs;
                            dvs   <= b_abs;
                            neg_q <= signed_div &&
                                     (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            neg_r <= signed_div && dividend[WIDTH-1];
                        end
                    end
                end
                BUSY: begin
                    if (!annul) begin
                        rem  <= rem_nx;
                        quot <= quot_nx;
                        cnt  <= cnt + 1'b1;
                        if (last) begin
                            div_result <= {r_fin, q_fin};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed stimulus for div_unit, checked every cycle
// against an arithmetic reference model plus hand-computed literals.
module tb_div_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           signed_div;
    logic [W-1:0]   dividend;
    logic [W-1:0]   divisor;
    logic           annul;
    logic [2*W-1:0] div_result;
    logic           done;
    logic           stall_req;

    int n_cmp = 0;
    int n_err = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .annul      (annul),
        .div_result (div_result),
        .done       (done),
        .stall_req  (stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic: truncating division on wide integers.
    function automatic logic [63:0] ref_div(input logic sd,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == '0) return {a, {W{1'b1}}};
        if (sd) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[W-1:0], q[W-1:0]};
    endfunction

    // Timing model: an accepted divide reports W+1 cycles later (1 for /0).
    bit          m_on = 1'b0;
    bit          m_act;
    int          m_left;
    logic [63:0] m_res;
    logic [63:0] m_pend;

    always @(posedge clk) begin
        if (rst) begin
            m_on   <= 1'b1;
            m_act  <= 1'b0;
            m_left <= 0;
            m_res  <= '0;
        end else if (m_act) begin
            if (m_left == 0) begin
                m_act <= 1'b0;
            end else if (annul) begin
                m_act <= 1'b0;
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) m_res <= m_pend;
            end
        end else if (start && !annul) begin
            m_act  <= 1'b1;
            m_pend <= ref_div(signed_div, dividend, divisor);
            if (divisor == '0) begin
                m_left <= 0;
                m_res  <= ref_div(signed_div, dividend, divisor);
            end else begin
                m_left <= W;
            end
        end
    end

    // Per-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        if (m_on) begin
            chk("cyc_done", 64'(done), 64'(m_act && m_left == 0));
            chk("cyc_stall", 64'(stall_req),
                64'(m_act ? (m_left != 0) : (start && !annul)));
            chk("cyc_result", div_result, m_res);
        end
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic sd, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        step();
        start      = 1'b1;
        signed_div = sd;
        dividend   = a;
        divisor    = b;
        @(negedge clk);
        chk("stall_c0", 64'(stall_req), 64'd1);
        step();
        start = 1'b0;
    endtask

    // cur = cycle number of the next negedge; bounded wait for done.
    task automatic wait_done(input string nm, input int cur,
                             input int exp_cyc, input logic [63:0] exp_res);
        int k;
        k = cur;
        @(negedge clk);
        while (!done && k < exp_cyc + 20) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_cyc"}, 64'(k), 64'(exp_cyc));
        chk({nm, "_res"}, div_result, exp_res);
        chk({nm, "_nostall"}, 64'(stall_req), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end

    initial begin
        int ndone;
        rst        = 1'b1;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        dividend   = '0;
        divisor    = '0;

        chk("mdl_u", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        chk("mdl_s1", ref_div(1'b1, -32'sd7, 32'd2),
            {32'hFFFFFFFF, 32'hFFFFFFFD});
        chk("mdl_s2", ref_div(1'b1, 32'd7, -32'sd2), {32'd1, 32'hFFFFFFFD});
        chk("mdl_s3", ref_div(1'b1, -32'sd7, -32'sd2), {32'hFFFFFFFF, 32'd3});
        chk("mdl_wrap", ref_div(1'b1, 32'h80000000, 32'hFFFFFFFF),
            {32'd0, 32'h80000000});

        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_res", div_result, 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_stall", 64'(stall_req), 64'd0);

        issue(1'b0, 32'd100, 32'd7);
        wait_done("udiv", 1, 33, {32'd2, 32'd14});

        issue(1'b1, -32'sd7, 32'd2);
        wait_done("sdiv1", 1, 33, {32'hFFFFFFFF, 32'hFFFFFFFD});
        issue(1'b1, 32'd7, -32'sd2);
        wait_done("sdiv2", 1, 33, {32'd1, 32'hFFFFFFFD});
        issue(1'b1, -32'sd7, -32'sd2);
        wait_done("sdiv3", 1, 33, {32'hFFFFFFFF, 32'd3});

        issue(1'b0, 32'h12345678, 32'd0);
        wait_done("dz", 1, 1, {32'h12345678, 32'hFFFFFFFF});
        issue(1'b1, 32'h80000000, 32'hFFFFFFFF);
        wait_done("wrap", 1, 33, {32'd0, 32'h80000000});

        // Annul mid-operation, then restart.
        issue(1'b0, 32'd50, 32'd5);
        repeat (9) @(posedge clk);
        #2;
        annul = 1'b1;
        step();
        annul = 1'b0;
        @(negedge clk);
        chk("ann_stall", 64'(stall_req), 64'd0);
        chk("ann_done", 64'(done), 64'd0);
        chk("ann_keep", div_result, {32'd0, 32'h80000000});
        issue(1'b0, 32'd50, 32'd5);
        wait_done("ann_re", 13, 45, {32'd0, 32'd10});

        // Annul together with start in IDLE drops the start.
        step();
        start    = 1'b1;
        annul    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
        @(negedge clk);
        chk("ann_start", 64'(stall_req), 64'd0);
        step();
        start = 1'b0;
        annul = 1'b0;
        repeat (3) step();

        // Start held: BUSY/DONE starts ignored, re-accept every 34 cycles.
        step();
        start      = 1'b1;
        signed_div = 1'b0;
        dividend   = 32'd200;
        divisor    = 32'd3;
        repeat (10) @(posedge clk);
        #2;
        dividend = 32'd999;
        wait_done("held1", 10, 33, {32'd2, 32'd66});
        wait_done("held2", 34, 67, {32'd0, 32'd333});
        step();
        start = 1'b0;
        repeat (3) step();

        // Reset mid-operation.
        issue(1'b0, 32'd1000, 32'd7);
        repeat (14) @(posedge clk);
        #2;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rmid_done", 64'(done), 64'd0);
        chk("rmid_stall", 64'(stall_req), 64'd0);
        chk("rmid_res", div_result, 64'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("rmid_nodone", 64'(ndone), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
